// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryptor: FSM state encoding,
// key geometry and the printable-ASCII window used by the plaintext check.
package arc4_pkg;

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RDI, K_WTI, K_RDJ, K_WTJ, K_WRI, K_WRJ,
    L_RD, L_WT, L_WR,
    P_RDI, P_WTI, P_RDJ, P_WTJ, P_WRI, P_WRJ, P_RDP, P_WTP, P_WR
  } state_t;

  localparam int KEY_BYTES = 3;
  localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  // Key byte 0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    is_printable = (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Control and memory-bus bundle of the ARC4 encryptor. The slave modport is
// the encryptor's view; the master modport is the host / memory side.
interface arc4_encrypt_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic        pt_err;

  modport master (
    output en, key, pt_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, pt_err
  );

  modport slave (
    input  en, key, pt_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, pt_err
  );
endinterface

// File: rtl/arc4_smem.sv
// 256x8 ARC4 state RAM: one synchronous read port (1-cycle latency) and one
// write port. Contents are not reset.
module arc4_smem (
  input  logic       clk,
  input  logic [7:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] mem_q [256];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: key schedule in arc4_smem, then length-prefixed PRGA over the
// plaintext image. Optional macro ARC4_PT_CHECK_EN enables the sticky pt_err flag.
module arc4_encrypt
  import arc4_pkg::*;
(
  input logic           clk,
  input logic           rst,
  arc4_encrypt_if.slave bus
);

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        ct_wren_q, ct_wren_d;
  logic [7:0]  ct_addr_q, ct_addr_d;
  logic [7:0]  ct_wrdata_q, ct_wrdata_d;
  logic [7:0]  pt_addr_q, pt_addr_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [7:0]  si_q, si_d, sj_q, sj_d, len_q, len_d;
  logic [23:0] key_q, key_d;
`ifdef ARC4_PT_CHECK_EN
  logic        pt_err_q, pt_err_d;
`endif

  logic [7:0] s_raddr, s_rdata, s_waddr, s_wdata;
  logic       s_we;

  arc4_smem u_smem (
    .clk   (clk),
    .raddr (s_raddr),
    .rdata (s_rdata),
    .we    (s_we),
    .waddr (s_waddr),
    .wdata (s_wdata)
  );

  // Each S read is issued in an *_RD* state and its data captured on the
  // following *_WT* -> next edge; addresses are held across both cycles.
  always_comb begin
    state_d     = state_q;
    ct_wren_d   = 1'b0;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    pt_addr_d   = pt_addr_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    kidx_d      = kidx_q;
    si_d        = si_q;
    sj_d        = sj_q;
    len_d       = len_q;
    key_d       = key_q;
`ifdef ARC4_PT_CHECK_EN
    pt_err_d    = pt_err_q;
`endif
    s_raddr     = i_q;
    s_we        = 1'b0;
    s_waddr     = i_q;
    s_wdata     = sj_q;

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          key_d     = bus.key;
          i_d       = 8'd0;
          j_d       = 8'd0;
          k_d       = 8'd0;
          kidx_d    = 2'd0;
          pt_addr_d = 8'd0;
`ifdef ARC4_PT_CHECK_EN
          pt_err_d  = 1'b0;
`endif
          state_d   = INIT;
        end
      end
      INIT: begin
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = i_q;
        i_d     = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = K_RDI;
      end
      K_RDI: state_d = K_WTI;
      K_WTI: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata + key_byte(key_q, kidx_q);
        state_d = K_RDJ;
      end
      K_RDJ: begin
        s_raddr = j_q;
        state_d = K_WTJ;
      end
      K_WTJ: begin
        s_raddr = j_q;
        sj_d    = s_rdata;
        state_d = K_WRI;
      end
      K_WRI: begin
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = sj_q;
        state_d = K_WRJ;
      end
      K_WRJ: begin
        s_we    = 1'b1;
        s_waddr = j_q;
        s_wdata = si_q;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
        state_d = (i_q == 8'hFF) ? L_RD : K_RDI;
      end
      L_RD: state_d = L_WT;
      L_WT: begin
        len_d       = bus.pt_rddata;
        ct_wren_d   = 1'b1;
        ct_addr_d   = 8'd0;
        ct_wrdata_d = bus.pt_rddata;
        state_d     = L_WR;
      end
      L_WR: begin
        j_d = 8'd0;
        if (len_q <= 8'd1) begin
          i_d     = 8'd0;
          state_d = IDLE;
        end else begin
          i_d       = 8'd1;
          k_d       = 8'd1;
          pt_addr_d = 8'd1;
          state_d   = P_RDI;
        end
      end
      P_RDI: state_d = P_WTI;
      P_WTI: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = P_RDJ;
      end
      P_RDJ: begin
        s_raddr = j_q;
        state_d = P_WTJ;
      end
      P_WTJ: begin
        s_raddr = j_q;
        sj_d    = s_rdata;
        state_d = P_WRI;
      end
      P_WRI: begin
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = sj_q;
        state_d = P_WRJ;
      end
      P_WRJ: begin
        s_we    = 1'b1;
        s_waddr = j_q;
        s_wdata = si_q;
        state_d = P_RDP;
      end
      P_RDP: begin
        s_raddr = si_q + sj_q;
        state_d = P_WTP;
      end
      P_WTP: begin
        s_raddr     = si_q + sj_q;
        ct_wren_d   = 1'b1;
        ct_addr_d   = k_q;
        ct_wrdata_d = s_rdata ^ bus.pt_rddata;
        state_d     = P_WR;
      end
      P_WR: begin
`ifdef ARC4_PT_CHECK_EN
        if (!is_printable(bus.pt_rddata)) pt_err_d = 1'b1;
`endif
        if (k_q == len_q - 8'd1) begin
          state_d = IDLE;
        end else begin
          k_d       = k_q + 8'd1;
          pt_addr_d = k_q + 8'd1;
          i_d       = i_q + 8'd1;
          state_d   = P_RDI;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      ct_wren_q   <= 1'b0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      pt_addr_q   <= 8'd0;
`ifdef ARC4_PT_CHECK_EN
      pt_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      ct_wren_q   <= ct_wren_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      pt_addr_q   <= pt_addr_d;
`ifdef ARC4_PT_CHECK_EN
      pt_err_q    <= pt_err_d;
`endif
    end
  end

  // Datapath registers carry no reset; every run re-initialises them on en accept.
  always_ff @(posedge clk) begin
    i_q    <= i_d;
    j_q    <= j_d;
    k_q    <= k_d;
    kidx_q <= kidx_d;
    si_q   <= si_d;
    sj_q   <= sj_d;
    len_q  <= len_d;
    key_q  <= key_d;
  end

  assign bus.rdy       = rdy_q;
  assign bus.ct_wren   = ct_wren_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wrdata_q;
  assign bus.pt_addr   = pt_addr_q;
`ifdef ARC4_PT_CHECK_EN
  assign bus.pt_err    = pt_err_q;
`else
  assign bus.pt_err    = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: a textbook ARC4 model fills a scoreboard of expected
// ciphertext writes; a monitor checks every ct_wren pulse against it.
module tb_arc4_encrypt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_encrypt_if bus ();

  arc4_encrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];

  always @(posedge clk) bus.pt_rddata <= pt_mem[bus.pt_addr];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Textbook ARC4 over the length-prefixed image currently in pt_mem.
  task automatic model(input logic [23:0] key);
    int s [256];
    int kb [3];
    int i, j, t, len, pad;
    wr_t w;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(pt_mem[0]);
    w.addr = 8'd0;
    w.data = pt_mem[0];
    exp_q.push_back(w);
    exp_err = 1'b0;
    i = 0;
    j = 0;
    for (int k = 1; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      pad = s[(s[i] + s[j]) % 256];
      w.addr = 8'(k);
      w.data = 8'(pad) ^ pt_mem[k];
      exp_q.push_back(w);
      if (pt_mem[k] < 8'h20 || pt_mem[k] > 8'h7E) exp_err = 1'b1;
    end
`ifndef ARC4_PT_CHECK_EN
    exp_err = 1'b0;
`endif
  endtask

  always @(negedge clk) begin
    if (bus.ct_wren === 1'b1) begin
      ct_mem[bus.ct_addr] = bus.ct_wrdata;
      if (exp_q.size() == 0) begin
        check("ct_unexpected_write", {24'd0, bus.ct_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("ct_addr", {24'd0, bus.ct_addr}, {24'd0, w.addr});
        check("ct_data", {24'd0, bus.ct_wrdata}, {24'd0, w.data});
      end
    end
  end

  // Start one run, optionally poking en mid-run, and check latency and flag.
  task automatic run(input logic [23:0] key, input bit poke);
    int n, busy, len;
    check("rdy_before_run", {31'd0, bus.rdy}, 32'd1);
    @(negedge clk);
    model(key);
    len  = int'(pt_mem[0]);
    busy = 256 + 1536 + 3 + 9 * ((len > 1) ? len - 1 : 0);
    bus.key = key;
    bus.en  = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    check("rdy_fall", {31'd0, bus.rdy}, 32'd0);
    n = 0;
    while (n < busy + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rdy) break;
      bus.en  = poke && (n == 100);
      bus.key = (poke && n == 100) ? ~key : key;
    end
    bus.en = 1'b0;
    check("busy_cycles", n, busy);
    check("ct_writes_missing", exp_q.size(), 32'd0);
    exp_q.delete();
    check("pt_err", {31'd0, bus.pt_err}, {31'd0, exp_err});
  endtask

  task automatic load_rand(input int len, input bit printable);
    pt_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++)
      pt_mem[n] = printable ? 8'(32 + $urandom_range(94)) : 8'($urandom_range(255));
  endtask

  initial begin
    logic [7:0] orig [32];
    int mism;

    for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.key = 24'h123456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b0;
    check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("rst_ct_wren", {31'd0, bus.ct_wren}, 32'd0);
    check("rst_pt_err", {31'd0, bus.pt_err}, 32'd0);
    check("rst_ct_addr", {24'd0, bus.ct_addr}, 32'd0);
    check("rst_ct_wrdata", {24'd0, bus.ct_wrdata}, 32'd0);
    check("rst_pt_addr", {24'd0, bus.pt_addr}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_en_ignored", {31'd0, bus.rdy}, 32'd1);

    // Short "Hell" message
    pt_mem[0] = 8'h05; pt_mem[1] = 8'h48; pt_mem[2] = 8'h65;
    pt_mem[3] = 8'h6C; pt_mem[4] = 8'h6C;
    run(24'h000018, 1'b0);

    // Length 0 and 1
    pt_mem[0] = 8'h00;
    run(24'h010203, 1'b0);
    pt_mem[0] = 8'h01;
    run(24'h0A0B0C, 1'b1);

    // Round trip: encrypt, feed ct back as pt, expect original text
    load_rand(32, 1'b1);
    for (int n = 0; n < 32; n++) orig[n] = pt_mem[n];
    run(24'h1E4600, 1'b0);
    for (int n = 0; n < 32; n++) pt_mem[n] = ct_mem[n];
    run(24'h1E4600, 1'b0);
    mism = 0;
    for (int n = 0; n < 32; n++) if (ct_mem[n] !== orig[n]) mism++;
    check("round_trip", mism, 32'd0);

    // Reset during KSA, then a clean restart
    @(negedge clk);
    bus.key = 24'h55AA33;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (600) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("midrst_ct_wren", {31'd0, bus.ct_wren}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_rand(20, 1'b1);
    run(24'hABCDEF, 1'b0);

    // Non-printable plaintext byte
    pt_mem[0] = 8'h03; pt_mem[1] = 8'h41; pt_mem[2] = 8'h0A;
    run(24'h314159, 1'b0);

    // Random keys, lengths and contents
    for (int r = 0; r < 6; r++) begin
      load_rand($urandom_range(24), r[0]);
      run(24'($urandom), r[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
